// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch unit for the five-stage pipeline.
//
// Owns the program counter and keeps at most one instruction-memory request
// outstanding. Each returned word is presented with its address and
// sequential successor, ready to load into the IF/ID register. A redirect
// from EX replaces the pc and flushes every buffered word. A fetch that was
// already in flight when the redirect arrived is flagged and its response
// is thrown away when it returns.
//
// Optional feature: define FETCH_SKID_EN to add a one-entry skid slot. The
// next request can then issue while IF/ID is stalled on the presented word.
// Without it, no request issues while an unconsumed word is held.
//
// Parameters
//   RESET_PC     first fetch address after reset
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-low
//   stall        IF/ID hold; the presented word is not consumed while high
//   redirect     taken branch/jump from EX, overrides everything else
//   redirect_pc  redirect target
//   imem_req     request valid (combinational)
//   imem_addr    request address, word aligned (combinational)
//   imem_gnt     request accepted when imem_req & imem_gnt
//   imem_rvalid  response valid
//   imem_rdata   response word
//   fetch_valid  instruction/PC_in/PC_new hold a live instruction
//   instruction  fetched word
//   PC_in        address of the fetched word
//   PC_new       PC_in + 4
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] instruction,
  output logic [31:0] PC_in,
  output logic [31:0] PC_new
);

  typedef enum logic {REQ, WAIT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic        discard;

  logic        consume;
  logic        space;
  logic        grant;
  logic        resp;
  logic        resp_keep;

`ifdef FETCH_SKID_EN
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
`endif

  always_comb begin
    consume = fetch_valid & ~stall;
`ifdef FETCH_SKID_EN
    // Room exists unless both slots stay occupied through this edge.
    space = ~(fetch_valid & skid_valid & ~consume);
`else
    space = ~fetch_valid | consume;
`endif
    imem_req   = reset & (state == REQ) & space;
    imem_addr  = pc;
    grant      = imem_req & imem_gnt;
    resp       = (state == WAIT) & imem_rvalid;
    resp_keep  = resp & ~discard;

    state_next = state;
    if (redirect) begin
      // Stay in WAIT only while a request is still outstanding after this edge.
      state_next = (((state == WAIT) & ~imem_rvalid) | grant) ? WAIT : REQ;
    end else if (grant) begin
      state_next = WAIT;
    end else if (resp) begin
      state_next = REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      fetch_addr  <= '0;
      discard     <= 1'b0;
      fetch_valid <= 1'b0;
      instruction <= '0;
      PC_in       <= '0;
      PC_new      <= '0;
`ifdef FETCH_SKID_EN
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
`endif
    end else begin
      state <= state_next;
      if (grant) begin
        fetch_addr <= pc;
      end

      if (redirect) begin
        pc          <= redirect_pc;
        discard     <= ((state == WAIT) & ~imem_rvalid) | grant;
        fetch_valid <= 1'b0;
`ifdef FETCH_SKID_EN
        skid_valid  <= 1'b0;
`endif
      end else begin
        if (grant) begin
          pc <= pc + 32'd4;
        end
        if (resp) begin
          discard <= 1'b0;
        end

`ifdef FETCH_SKID_EN
        if (consume && skid_valid) begin
          // Skid advances into the output; a response landing now refills the skid.
          fetch_valid <= 1'b1;
          instruction <= skid_instr;
          PC_in       <= skid_pc;
          PC_new      <= skid_pc + 32'd4;
          skid_valid  <= resp_keep;
          if (resp_keep) begin
            skid_instr <= imem_rdata;
            skid_pc    <= fetch_addr;
          end
        end else if (resp_keep && (!fetch_valid || consume)) begin
          fetch_valid <= 1'b1;
          instruction <= imem_rdata;
          PC_in       <= fetch_addr;
          PC_new      <= fetch_addr + 32'd4;
        end else if (resp_keep) begin
          skid_valid <= 1'b1;
          skid_instr <= imem_rdata;
          skid_pc    <= fetch_addr;
        end else if (consume) begin
          fetch_valid <= 1'b0;
        end
`else
        if (resp_keep) begin
          fetch_valid <= 1'b1;
          instruction <= imem_rdata;
          PC_in       <= fetch_addr;
          PC_new      <= fetch_addr + 32'd4;
        end else if (consume) begin
          fetch_valid <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch. A behavioural instruction memory with
// programmable grant delay and response latency drives the fetch unit.
// Stimulus pushes the expected grant addresses and delivered words into
// queues. The memory process checks grants, and a monitor checks every
// presented word against the head of the expected-word queue.
module tb_if_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] instruction;
  logic [31:0] PC_in;
  logic [31:0] PC_new;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat      = 1;
  int gnt_wait = 0;

  logic [31:0] gnt_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_new_q[$];

  // memory model state
  bit          pend      = 1'b0;
  int          due       = 0;
  logic [31:0] paddr     = '0;
  int          req_wait  = 0;
  bit          prev_ungr = 1'b0;
  logic [31:0] prev_addr = '0;
  bit          prev_redir = 1'b0;
  logic [31:0] gnt_exp;
  logic [31:0] pop_dummy;

  if_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fetch_valid (fetch_valid),
    .instruction (instruction),
    .PC_in       (PC_in),
    .PC_new      (PC_new)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] pnew);
    exp_pc_q.push_back(pc);
    exp_new_q.push_back(pnew);
  endtask

  // Instruction memory: decisions made on the falling edge, seen by the DUT
  // on the following rising edge.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_rvalid = 1'b0;
      if (pend && cyc >= due) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(paddr);
        pend        = 1'b0;
      end
      if (prev_ungr && imem_req && !prev_redir)
        check32("addr_stable", imem_addr, prev_addr);
      imem_gnt = imem_req && !pend && (req_wait >= gnt_wait);
      if (imem_gnt) begin
        pend     = 1'b1;
        due      = cyc + lat;
        paddr    = imem_addr;
        req_wait = 0;
        if (gnt_q.size() != 0) begin
          gnt_exp = gnt_q.pop_front();
          check32("grant_addr", imem_addr, gnt_exp);
        end
      end else if (imem_req) begin
        req_wait++;
      end else begin
        req_wait = 0;
      end
      prev_ungr  = imem_req && !imem_gnt;
      prev_addr  = imem_addr;
      prev_redir = redirect;
    end
  end

  // Output monitor: a presented word must match the head of the expected
  // queue; it is retired when consumed or flushed by a redirect.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && fetch_valid) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got PC_in %h want no word", PC_in);
        end else begin
          check32("PC_in", PC_in, exp_pc_q[0]);
          check32("PC_new", PC_new, exp_new_q[0]);
          check32("instruction", instruction, memf(exp_pc_q[0]));
          if (!stall || redirect) begin
            pop_dummy = exp_pc_q.pop_front();
            pop_dummy = exp_new_q.pop_front();
          end
        end
      end
    end
  end

  task automatic do_reset;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check32("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check32("rst_instruction", instruction, 32'd0);
        check32("rst_PC_in", PC_in, 32'd0);
        check32("rst_PC_new", PC_new, 32'd0);
        check32("rst_imem_req", 32'(imem_req), 32'd0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_pc_q.size() != 0 || gnt_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words %0d grants pending want 0", exp_pc_q.size(), gnt_q.size());
      exp_pc_q.delete(); exp_new_q.delete(); gnt_q.delete();
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Sequential fetch from RESET_PC, then redirect in the 0x108 grant cycle.
    lat = 1; gnt_wait = 0;
    gnt_q.push_back(32'h100); gnt_q.push_back(32'h104);
    gnt_q.push_back(32'h108); gnt_q.push_back(32'h200);
    push_word(32'h100, 32'h104); push_word(32'h104, 32'h108);
    push_word(32'h200, 32'h204);
    do_reset;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check32("req_108", 32'(imem_req), 32'd1);
    check32("addr_108", imem_addr, 32'h108);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect = 1'b0;
    check32("redir_flush", 32'(fetch_valid), 32'd0);
    drain;

    // Wraparound: redirect to the last word of the address space.
    lat = 1; gnt_wait = 0;
    gnt_q.push_back(32'h100); gnt_q.push_back(32'hFFFF_FFFC); gnt_q.push_back(32'h0);
    push_word(32'hFFFF_FFFC, 32'h0000_0000); push_word(32'h0, 32'h4);
    do_reset;
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect = 1'b0;
    drain;

    // Stall held for six cycles with the 0x100 word presented.
    lat = 1; gnt_wait = 0;
    push_word(32'h100, 32'h104); push_word(32'h104, 32'h108); push_word(32'h108, 32'h10C);
    do_reset;
    reset = 1'b1; stall = 1'b1;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check32("stall_hold_valid", 32'(fetch_valid), 32'd1);
`ifndef FETCH_SKID_EN
      check32("stall_no_req", 32'(imem_req), 32'd0);
`endif
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk); @(negedge clk);
`ifdef FETCH_SKID_EN
    check32("skid_deliver", 32'(fetch_valid), 32'd1);
    check32("skid_deliver_pc", PC_in, 32'h104);
`else
    check32("noskid_gap", 32'(fetch_valid), 32'd0);
`endif
    drain;

    // Redirect together with stall: redirect wins, held word is flushed.
    lat = 1; gnt_wait = 0;
    push_word(32'h100, 32'h104); push_word(32'h300, 32'h304);
    do_reset;
    reset = 1'b1; stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1;
    redirect = 1'b0; stall = 1'b0;
    check32("redir_stall_flush", 32'(fetch_valid), 32'd0);
    drain;

    // Slow memory: grant withheld two cycles, response three cycles later.
    lat = 3; gnt_wait = 2;
    gnt_q.push_back(32'h100); gnt_q.push_back(32'h104);
    push_word(32'h100, 32'h104); push_word(32'h104, 32'h108);
    do_reset;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check32("slow_req", 32'(imem_req), 32'd1);
      check32("slow_addr", imem_addr, 32'h100);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32("slow_not_yet", 32'(fetch_valid), 32'd0);
    end
    @(negedge clk);
    check32("slow_arrive", 32'(fetch_valid), 32'd1);
    drain;

    // Reset while a fetch is outstanding: the late response is ignored.
    lat = 3; gnt_wait = 0;
    push_word(32'h100, 32'h104);
    do_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("stale_ignored", 32'(fetch_valid), 32'd0);
    end
    @(negedge clk);
    check32("post_reset_valid", 32'(fetch_valid), 32'd1);
    check32("post_reset_pc", PC_in, 32'h100);
    drain;

    do_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit for the five-stage pipeline. Owns the program counter, issues single-outstanding requests to instruction memory, and produces the fetched word with its address and sequential successor, ready to load into the IF/ID pipeline register. Honours downstream stall and branch/jump redirect from the execute stage, discarding any in-flight fetch made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset); one clock, no other clock domains
- stall  in  1  IF/ID hold; presented word is not consumed while high
- redirect  in  1  taken branch/jump from EX; priority over all other inputs
- redirect_pc  in  32  target address, sampled when redirect=1
- imem_req  out  1  request valid
- imem_addr  out  32  request address (word aligned)
- imem_gnt  in  1  memory accepts request when imem_req & imem_gnt
- imem_rvalid  in  1  response valid, earliest one cycle after grant
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- fetch_valid  out  1  instruction/PC_in/PC_new hold a live instruction
- instruction  out  32  fetched word, to IF/ID instruction
- PC_in  out  32  address of fetched word, to IF/ID PC_in
- PC_new  out  32  PC_in + 4 (mod 2^32), to IF/ID PC_new

## Operation
- State: pc (next fetch address), FSM {REQ, WAIT}, discard flag, output slot, optional skid slot.
- Consume: output slot is consumed in any cycle with fetch_valid=1 and stall=0.
- REQ: imem_req=1 when reset=1 and space is available, imem_addr=pc. Space: (occupied slots minus one if consuming this cycle) < capacity; capacity 1 without skid, 2 with skid. On grant: latch fetch address, pc <= pc+4, go WAIT.
- WAIT: imem_req=0. On imem_rvalid: if discard, drop word, clear discard; else write {rdata, fetch address, fetch address+4} into output slot if it is empty or being consumed, otherwise into skid slot. Go REQ.
- Skid to output: when output consumed and skid valid, skid moves to output same edge; an arriving response then goes to skid.
- Redirect (any state): pc <= redirect_pc; fetch_valid and skid valid cleared; if in WAIT without rvalid this cycle, or granted this cycle, set discard; FSM ends in WAIT if a request remains outstanding, else REQ. A response arriving in the redirect cycle is dropped.
- In REQ without grant, imem_addr may change (redirect); memory must sample only on grant.
- imem_rvalid while no request outstanding is ignored.
- pc wraps 32'hFFFF_FFFC -> 32'h0000_0000; PC_new wraps likewise.

## Timing
- Reset (reset=0 at edge): FSM=REQ, pc=RESET_PC, discard=0, fetch_valid=0, skid empty, instruction=0, PC_in=0, PC_new=0; imem_req=0 during reset. Reset mid-transaction abandons the outstanding request; a later rvalid is ignored.
- First request in first cycle with reset=1.
- Grant at cycle t, rvalid at t+k (k>=1): fetch_valid=1 from cycle t+k+1.
- Zero-wait memory (gnt held, rvalid one cycle after grant): one instruction per 2 cycles.
- imem_req depends combinationally on stall, fetch_valid, FSM; all outputs except imem_req/imem_addr are registered.
- Simultaneous redirect and stall: redirect wins; fetch_valid=0 next cycle.

## Configuration
- FETCH_SKID_EN defined: skid slot present, capacity 2; next request may issue while the output slot is held by stall.
- FETCH_SKID_EN undefined: no skid slot, capacity 1; no request issues while an unconsumed word is held, so a response always lands in the output slot.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait memory, stall=0 -> requests at 0x100, 0x104, 0x108; PC_in/PC_new pairs 0x100/0x104, 0x104/0x108; all outputs 0 during reset.
- Redirect to 0x0000_0200 in cycle of grant for 0x108 -> 0x108 response dropped, next fetch_valid carries PC_in=0x200, PC_new=0x204.
- stall held 6 cycles with word at 0x100 presented -> outputs stable, no lost/duplicate words; with FETCH_SKID_EN, 0x104 fetched and delivered on cycle after stall release; without it, no imem_req until release.
- Memory with 3-cycle rvalid delay and gnt low 2 cycles -> imem_addr stable while ungranted, fetch_valid 4 cycles after grant, in order.
- pc=32'hFFFF_FFFC fetch -> PC_new=0, next request addr 0x0.
- reset=0 while in WAIT, rvalid arrives after release -> rvalid ignored, first delivered word is from RESET_PC.
